// File: rtl/packet_word_packer_if.sv
// packet_word_packer_if: beat ingress and word egress bundle for packet_word_packer
// master: beat source and word consumer (drives push*, flush, pop)
// slave : the packer (drives pushReady, popValid, popData, popChannel, popLength, pop metadata)
interface packet_word_packer_if #(
    parameter int parallelWidth = 512,
    parameter int serialWidth = 8,
    parameter int channels = 4
);
    localparam int beats = parallelWidth / serialWidth;
    localparam int LW = $clog2(beats) + 1;
    localparam int CW = channels > 1 ? $clog2(channels) : 1;
    logic [channels-1:0] push;
    logic [channels*serialWidth-1:0] pushData;
    logic [channels-1:0] pushStartOfFrame;
    logic [channels-1:0] pushEndOfFrame;
    logic [channels-1:0] pushError;
    logic [channels-1:0] flush;
    logic [channels-1:0] pushReady;
    logic popValid;
    logic pop;
    logic [parallelWidth-1:0] popData;
    logic [CW-1:0] popChannel;
    logic [LW-1:0] popLength;
    logic popStartOfFrame;
    logic popEndOfFrame;
    logic popError;
    modport master (
        output push, pushData, pushStartOfFrame, pushEndOfFrame, pushError, flush, pop,
        input pushReady, popValid, popData, popChannel, popLength, popStartOfFrame, popEndOfFrame, popError
    );
    modport slave (
        input push, pushData, pushStartOfFrame, pushEndOfFrame, pushError, flush, pop,
        output pushReady, popValid, popData, popChannel, popLength, popStartOfFrame, popEndOfFrame, popError
    );
endinterface

// File: rtl/packet_word_packer.sv
// packet_word_packer: packs per-channel serial beats into framed words, buffers them and merges channels round-robin
// clk  : single clock
// rstn : asynchronous active-low reset
// bus  : slave side of packet_word_packer_if (per-channel beat inputs with pushReady, one valid/pop word output)
module packet_word_packer #(
    parameter int parallelWidth = 512,
    parameter int serialWidth = 8,
    parameter int channels = 4,
    parameter int depth = 4
) (
    input logic clk,
    input logic rstn,
    packet_word_packer_if.slave bus
);
    localparam int beats = parallelWidth / serialWidth;
    localparam int LW = $clog2(beats) + 1;
    localparam int CW = channels > 1 ? $clog2(channels) : 1;
    localparam int OW = $clog2(depth + 1);
    localparam int PW = $clog2(depth);

    typedef struct packed {
        logic [parallelWidth-1:0] data;
        logic [LW-1:0] len;
        logic sof;
        logic eof;
        logic err;
    } word_t;

    logic [parallelWidth-1:0] asm_q [channels];
    logic [parallelWidth-1:0] asm_d [channels];
    logic [LW-1:0] cnt_q [channels];
    logic [LW-1:0] cnt_d [channels];
    logic [OW-1:0] occ_q [channels];
    logic [OW-1:0] occ_d [channels];
    logic [PW-1:0] wp_q [channels];
    logic [PW-1:0] wp_d [channels];
    logic [PW-1:0] rp_q [channels];
    logic [PW-1:0] rp_d [channels];
    logic [channels-1:0] sof_q, sof_d, err_q, err_d, ready, acc, wr, rd;
    word_t wword [channels];
    word_t mem_q [channels][depth];
    word_t out_q, out_d;
    logic vld_q, vld_d, found, load;
    logic [CW-1:0] rr_q, rr_d, ch_q, ch_d, grant;

    // First non-empty FIFO scanning upward from rr wins; the output register
    // refills whenever it is empty or being drained this cycle.
    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int i = 0; i < channels; i++) begin
            if (!found && occ_q[(int'(rr_q) + i) % channels] != '0) begin
                found = 1'b1;
                grant = CW'((int'(rr_q) + i) % channels);
            end
        end
        load = (!vld_q || bus.pop) && found;
        out_d = load ? mem_q[grant][rp_q[grant]] : out_q;
        vld_d = load || (vld_q && !bus.pop);
        ch_d = load ? grant : ch_q;
        rr_d = load ? (int'(grant) == channels - 1 ? '0 : grant + 1'b1) : rr_q;
    end

    // The assembly register is cleared on every close, so OR-ing the beat into
    // lane cnt is enough and unused lanes stay zero.
    always_comb begin
        for (int c = 0; c < channels; c++) begin
            ready[c] = occ_q[c] < OW'(depth);
            acc[c] = bus.push[c] && ready[c];
            wword[c].data = acc[c] ? asm_q[c] | (parallelWidth'(bus.pushData[c*serialWidth +: serialWidth]) << (int'(cnt_q[c]) * serialWidth)) : asm_q[c];
            wword[c].len = cnt_q[c] + LW'(acc[c]);
            wword[c].sof = sof_q[c] || (acc[c] && bus.pushStartOfFrame[c]);
            wword[c].err = err_q[c] || (acc[c] && bus.pushError[c]);
            wword[c].eof = acc[c] && bus.pushEndOfFrame[c];
            // A partial word always has FIFO room: only a close raises occupancy,
            // and a close empties the assembly register.
            wr[c] = acc[c] ? (int'(cnt_q[c]) == beats - 1 || bus.pushEndOfFrame[c] || bus.flush[c])
                           : (bus.flush[c] && cnt_q[c] != '0 && ready[c]);
            rd[c] = load && int'(grant) == c;
            asm_d[c] = wr[c] ? '0 : wword[c].data;
            cnt_d[c] = wr[c] ? '0 : wword[c].len;
            sof_d[c] = !wr[c] && wword[c].sof;
            err_d[c] = !wr[c] && wword[c].err;
            occ_d[c] = occ_q[c] + OW'(wr[c]) - OW'(rd[c]);
            wp_d[c] = wr[c] ? (int'(wp_q[c]) == depth - 1 ? '0 : wp_q[c] + 1'b1) : wp_q[c];
            rp_d[c] = rd[c] ? (int'(rp_q[c]) == depth - 1 ? '0 : rp_q[c] + 1'b1) : rp_q[c];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int c = 0; c < channels; c++) begin
                asm_q[c] <= '0;
                cnt_q[c] <= '0;
                occ_q[c] <= '0;
                wp_q[c] <= '0;
                rp_q[c] <= '0;
            end
            sof_q <= '0;
            err_q <= '0;
            out_q <= '0;
            vld_q <= 1'b0;
            rr_q <= '0;
            ch_q <= '0;
        end else begin
            for (int c = 0; c < channels; c++) begin
                asm_q[c] <= asm_d[c];
                cnt_q[c] <= cnt_d[c];
                occ_q[c] <= occ_d[c];
                wp_q[c] <= wp_d[c];
                rp_q[c] <= rp_d[c];
            end
            sof_q <= sof_d;
            err_q <= err_d;
            out_q <= out_d;
            vld_q <= vld_d;
            rr_q <= rr_d;
            ch_q <= ch_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int c = 0; c < channels; c++) begin
            if (wr[c]) mem_q[c][wp_q[c]] <= wword[c];
        end
    end

    assign bus.pushReady = ready;
    assign bus.popValid = vld_q;
    assign bus.popData = out_q.data;
    assign bus.popChannel = ch_q;
    assign bus.popLength = out_q.len;
    assign bus.popStartOfFrame = out_q.sof;
    assign bus.popEndOfFrame = out_q.eof;
    assign bus.popError = out_q.err;
endmodule

// File: tb/tb_packet_word_packer.sv
// tb_packet_word_packer: directed bench for packet_word_packer with default parameters (512/8, 4 channels, depth 4)
module tb_packet_word_packer;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    int checks = 0;
    int errors = 0;
    int cyc = 0;

    packet_word_packer_if #(.parallelWidth(512), .serialWidth(8), .channels(4)) bus ();

    packet_word_packer #(.parallelWidth(512), .serialWidth(8), .channels(4), .depth(4)) dut (
        .clk(clk),
        .rstn(rstn),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [511:0] d;
        int len;
        int ch;
        bit s;
        bit e;
        bit r;
        int cyc;
    } rec_t;

    typedef struct {
        int ch;
        int n;
        logic [7:0] base;
        bit sof;
        bit eof;
        int errb;
        int exp_len;
        bit exp_sof;
        bit exp_eof;
        bit exp_err;
    } vec_t;

    rec_t q[$];
    rec_t mon;

    always @(negedge clk) begin
        if (rstn && bus.popValid && bus.pop) begin
            mon.d = bus.popData;
            mon.len = int'(bus.popLength);
            mon.ch = int'(bus.popChannel);
            mon.s = bus.popStartOfFrame;
            mon.e = bus.popEndOfFrame;
            mon.r = bus.popError;
            mon.cyc = cyc;
            q.push_back(mon);
        end
    end

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [511:0] mkword(input logic [7:0] base, input int n);
        logic [511:0] w = '0;
        for (int i = 0; i < n; i++) w[i*8 +: 8] = base + 8'(i);
        return w;
    endfunction

    task automatic clear_in();
        bus.push = '0;
        bus.pushData = '0;
        bus.pushStartOfFrame = '0;
        bus.pushEndOfFrame = '0;
        bus.pushError = '0;
        bus.flush = '0;
    endtask

    task automatic beat(input int ch, input logic [7:0] d, input bit p, input bit s, input bit e, input bit r, input bit f);
        clear_in();
        bus.push[ch] = p;
        bus.pushData[ch*8 +: 8] = d;
        bus.pushStartOfFrame[ch] = s;
        bus.pushEndOfFrame[ch] = e;
        bus.pushError[ch] = r;
        bus.flush[ch] = f;
        @(posedge clk);
        #1;
        clear_in();
    endtask

    task automatic idle(input int n);
        clear_in();
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic all_close(input logic [7:0] base);
        clear_in();
        for (int c = 0; c < 4; c++) bus.pushData[c*8 +: 8] = base + 8'(c);
        bus.push = 4'hf;
        bus.pushStartOfFrame = 4'hf;
        bus.pushEndOfFrame = 4'hf;
        @(posedge clk);
        #1;
        clear_in();
    endtask

    vec_t vt[5];

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        vt[0] = '{0, 64, 8'h00, 1'b1, 1'b1, -1, 64, 1'b1, 1'b1, 1'b0};
        vt[1] = '{1, 3, 8'hA1, 1'b1, 1'b1, 1, 3, 1'b1, 1'b1, 1'b1};
        vt[2] = '{3, 1, 8'h5C, 1'b1, 1'b1, -1, 1, 1'b1, 1'b1, 1'b0};
        vt[3] = '{2, 64, 8'h80, 1'b1, 1'b0, -1, 64, 1'b1, 1'b0, 1'b0};
        vt[4] = '{0, 10, 8'hF8, 1'b0, 1'b1, 9, 10, 1'b0, 1'b1, 1'b1};
        clear_in();
        bus.pop = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", bus.popValid, 0);
        chk("rst_data", bus.popData, 0);
        chk("rst_chan", bus.popChannel, 0);
        chk("rst_len", bus.popLength, 0);
        chk("rst_meta", {bus.popStartOfFrame, bus.popEndOfFrame, bus.popError}, 0);
        chk("rst_ready", bus.pushReady, 4'hf);
        rstn = 1'b1;
        bus.pop = 1'b1;
        idle(2);

        for (int v = 0; v < 5; v++) begin
            for (int i = 0; i < vt[v].n; i++)
                beat(vt[v].ch, vt[v].base + 8'(i), 1'b1, vt[v].sof && i == 0, vt[v].eof && i == vt[v].n - 1, i == vt[v].errb, 1'b0);
            chk($sformatf("v%0d_lat0", v), bus.popValid, 0);
            idle(1);
            chk($sformatf("v%0d_lat1", v), bus.popValid, 1);
            chk($sformatf("v%0d_chan", v), bus.popChannel, vt[v].ch);
            chk($sformatf("v%0d_len", v), bus.popLength, vt[v].exp_len);
            chk($sformatf("v%0d_sof", v), bus.popStartOfFrame, vt[v].exp_sof);
            chk($sformatf("v%0d_eof", v), bus.popEndOfFrame, vt[v].exp_eof);
            chk($sformatf("v%0d_err", v), bus.popError, vt[v].exp_err);
            chk($sformatf("v%0d_data", v), bus.popData, mkword(vt[v].base, vt[v].n));
            idle(1);
            chk($sformatf("v%0d_drain", v), bus.popValid, 0);
        end

        // flush-only close, flush with a beat, flush on an empty word
        q.delete();
        for (int i = 0; i < 5; i++) beat(2, 8'h20 + 8'(i), 1'b1, i == 0, 1'b0, 1'b0, 1'b0);
        beat(2, 8'hEE, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        beat(2, 8'h25, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        beat(2, 8'h26, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(3);
        beat(1, 8'h90, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        beat(1, 8'h91, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(3);
        beat(1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(4);
        chk("a_count", q.size(), 3);
        if (q.size() == 3) begin
            chk("a0_len", q[0].len, 5);
            chk("a0_meta", {q[0].s, q[0].e, q[0].r}, 3'b100);
            chk("a0_data", q[0].d, mkword(8'h20, 5));
            chk("a0_chan", q[0].ch, 2);
            chk("a1_len", q[1].len, 2);
            chk("a1_meta", {q[1].s, q[1].e, q[1].r}, 3'b010);
            chk("a1_data", q[1].d, mkword(8'h25, 2));
            chk("a2_len", q[2].len, 2);
            chk("a2_eof", q[2].e, 0);
            chk("a2_data", q[2].d, mkword(8'h90, 2));
            chk("a2_chan", q[2].ch, 1);
        end

        // round-robin from a fresh pointer, twice
        rstn = 1'b0;
        idle(2);
        rstn = 1'b1;
        q.delete();
        all_close(8'h40);
        idle(6);
        all_close(8'h50);
        idle(6);
        chk("b_count", q.size(), 8);
        if (q.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
                chk($sformatf("b%0d_chan", i), q[i].ch, i % 4);
                chk($sformatf("b%0d_data", i), q[i].d, mkword((i < 4 ? 8'h40 : 8'h50) + 8'(i % 4), 1));
                if (i % 4 != 0) chk($sformatf("b%0d_gap", i), q[i].cyc - q[i-1].cyc, 1);
            end
        end

        // backpressure on channel 3
        bus.pop = 1'b0;
        q.delete();
        for (int i = 0; i < 5; i++) begin
            beat(3, 8'h30 + 8'(i), 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
            if (i == 3) chk("c_ready_depth_m1", bus.pushReady[3], 1);
        end
        chk("c_ready_full", bus.pushReady[3], 0);
        beat(3, 8'h3F, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("c_ready_hold", bus.pushReady[3], 0);
        chk("c_other_ready", bus.pushReady[2:0], 3'b111);
        chk("c_valid_hold", bus.popValid, 1);
        chk("c_data_hold", bus.popData, mkword(8'h30, 1));
        chk("c_no_xfer", q.size(), 0);
        bus.pop = 1'b1;
        idle(10);
        chk("c_count", q.size(), 5);
        if (q.size() == 5)
            for (int i = 0; i < 5; i++) chk($sformatf("c%0d_order", i), q[i].d, mkword(8'h30 + 8'(i), 1));
        chk("c_ready_back", bus.pushReady[3], 1);

        // asynchronous reset with queued and partial words
        bus.pop = 1'b0;
        q.delete();
        beat(0, 8'h60, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        beat(0, 8'h61, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        beat(0, 8'h62, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("d_pre_valid", bus.popValid, 1);
        #3 rstn = 1'b0;
        #1;
        chk("d_rst_valid", bus.popValid, 0);
        chk("d_rst_data", bus.popData, 0);
        chk("d_rst_len", bus.popLength, 0);
        chk("d_rst_meta", {bus.popStartOfFrame, bus.popEndOfFrame, bus.popError}, 0);
        chk("d_rst_ready", bus.pushReady, 4'hf);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        bus.pop = 1'b1;
        idle(8);
        chk("d_no_stale", q.size(), 0);
        beat(0, 8'h77, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        idle(4);
        chk("d_count", q.size(), 1);
        if (q.size() == 1) begin
            chk("d_len", q[0].len, 1);
            chk("d_data", q[0].d, mkword(8'h77, 1));
            chk("d_meta", {q[0].s, q[0].e, q[0].r}, 3'b110);
            chk("d_chan", q[0].ch, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
